fir_filter_mc: RTL and testbench

Parametrised, time-multiplexed single-MAC FIR filter for N_CH interleaved audio channels. Each channel has its own sample history and its own coefficient set. It generalises the codec-path stereo FIR in five ways: parametrised widths, tap count and channel count; runtime-loadable coefficients; history clearing after reset; round-to-nearest output; and explicit busy/drop/overflow reporting. It sits between the codec receive interface and the codec transmit interface.

---
 rtl/fir_filter_mc.sv | 181 ++++++++++++++++++
 tb/tb_fir_filter_mc.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_filter_mc.sv
// Time-multiplexed single-MAC FIR for N_CH interleaved channels, one tap per cycle; dout_valid TAPS+MUL_LAT+2 cycles after accept.
// Backpressure: din_ready only in IDLE; samples offered while busy, or multi-hot din_valid, are dropped with a drop pulse.
module fir_filter_mc #(
    parameter int DATA_W    = 24,
    parameter int COEF_W    = 35,
    parameter int COEF_FRAC = 31,
    parameter int TAPS      = 256,
    parameter int N_CH      = 2,
    parameter int MUL_LAT   = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [N_CH-1:0]                       din_valid,
    input  logic [DATA_W-1:0]                     din,
    output logic                                  din_ready,
    output logic [N_CH-1:0]                       dout_valid,
    output logic [DATA_W-1:0]                     dout,
    output logic                                  drop,
    output logic                                  ovf,
    input  logic                                  ovf_clr,
    input  logic                                  coef_we,
    input  logic [$clog2(N_CH)+$clog2(TAPS)-1:0]  coef_addr,
    input  logic [COEF_W-1:0]                     coef_din
);
    localparam int CH_W   = $clog2(N_CH);
    localparam int CH_IW  = (CH_W > 0) ? CH_W : 1;
    localparam int TAP_W  = $clog2(TAPS);
    localparam int ADDR_W = CH_W + TAP_W;
    localparam int DEPTH  = N_CH * TAPS;
    localparam int CNT_W  = (ADDR_W > $clog2(MUL_LAT + 1)) ? ADDR_W : $clog2(MUL_LAT + 1);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = PROD_W + TAP_W;
    localparam int RND_W  = ACC_W + 1;
    localparam int SHF_W  = RND_W - COEF_FRAC;
    localparam logic signed [RND_W-1:0] HALF = RND_W'(1) << (COEF_FRAC - 1);

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_RUN, S_DRAIN, S_OUT} state_t;

    state_t                   state, nstate;
    logic [CNT_W-1:0]         cnt;
    logic                     accept, reject, hist_we;
    logic [CH_IW-1:0]         in_ch, ch_q;
    logic [TAP_W-1:0]         wptr [N_CH];
    logic [TAP_W-1:0]         base_q, tap;
    logic [ADDR_W-1:0]        hist_waddr, hist_raddr, coef_raddr;
    logic [DATA_W-1:0]        hist_wdat;

    logic [DATA_W-1:0]        hist_mem [DEPTH];
    logic [COEF_W-1:0]        coef_mem [DEPTH] = '{default: '0};
    logic signed [DATA_W-1:0] hist_q;
    logic signed [COEF_W-1:0] coef_q;
    logic [MUL_LAT-1:0]       vld_pipe, first_pipe;
    logic signed [PROD_W-1:0] prod_pipe [MUL_LAT-1];
    logic signed [ACC_W-1:0]  acc;
    logic signed [SHF_W-1:0]  shf;
    logic                     sat;
    logic [DATA_W-1:0]        conv;

    function automatic logic [ADDR_W-1:0] mk_addr(input logic [CH_IW-1:0] ch, input logic [TAP_W-1:0] k);
        return (ADDR_W'(ch) << TAP_W) | ADDR_W'(k);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_INIT;
            cnt   <= '0;
        end else begin
            state <= nstate;
            if (nstate != state || state == S_IDLE)
                cnt <= '0;
            else
                cnt <= cnt + CNT_W'(1);
        end
    end

    always_comb begin
        nstate = state;
        case (state)
            S_INIT:  if (cnt == CNT_W'(DEPTH - 1))   nstate = S_IDLE;
            S_IDLE:  if (accept)                      nstate = S_RUN;
            S_RUN:   if (cnt == CNT_W'(TAPS - 1))    nstate = S_DRAIN;
            S_DRAIN: if (cnt == CNT_W'(MUL_LAT - 1)) nstate = S_OUT;
            S_OUT:                                    nstate = S_IDLE;
            default:                                  nstate = S_INIT;
        endcase
    end

    always_comb begin
        din_ready = (state == S_IDLE);
        accept    = din_ready && $onehot(din_valid);
        reject    = (din_valid != '0) && !accept;
    end

    always_comb begin
        in_ch = '0;
        for (int c = 0; c < N_CH; c++)
            if (din_valid[c]) in_ch = CH_IW'(c);
    end

    // Newest sample sits at base_q, so tap k reads base_q - k.
    always_comb begin
        tap        = cnt[TAP_W-1:0];
        hist_we    = !rst && (state == S_INIT || accept);
        hist_waddr = (state == S_INIT) ? cnt[ADDR_W-1:0] : mk_addr(in_ch, wptr[in_ch]);
        hist_wdat  = (state == S_INIT) ? '0 : din;
        hist_raddr = mk_addr(ch_q, base_q - tap);
        coef_raddr = mk_addr(ch_q, tap);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < N_CH; c++) wptr[c] <= '0;
            ch_q   <= '0;
            base_q <= '0;
        end else if (accept) begin
            wptr[in_ch] <= wptr[in_ch] + TAP_W'(1);
            ch_q        <= in_ch;
            base_q      <= wptr[in_ch];
        end
    end

    always_ff @(posedge clk) begin
        if (hist_we) hist_mem[hist_waddr] <= hist_wdat;
        hist_q <= hist_mem[hist_raddr];
    end

    // Read-before-write: a tap read in the same cycle as a write sees the old coefficient.
    always_ff @(posedge clk) begin
        if (coef_we) coef_mem[coef_addr] <= coef_din;
        coef_q <= coef_mem[coef_raddr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe   <= '0;
            first_pipe <= '0;
        end else begin
            vld_pipe   <= {vld_pipe[MUL_LAT-2:0], state == S_RUN};
            first_pipe <= {first_pipe[MUL_LAT-2:0], state == S_RUN && cnt == '0};
        end
    end

    always_ff @(posedge clk) begin
        prod_pipe[0] <= hist_q * coef_q;
        for (int i = 1; i < MUL_LAT - 1; i++) prod_pipe[i] <= prod_pipe[i-1];
        if (vld_pipe[MUL_LAT-1]) begin
            if (first_pipe[MUL_LAT-1])
                acc <= {{TAP_W{prod_pipe[MUL_LAT-2][PROD_W-1]}}, prod_pipe[MUL_LAT-2]};
            else
                acc <= acc + {{TAP_W{prod_pipe[MUL_LAT-2][PROD_W-1]}}, prod_pipe[MUL_LAT-2]};
        end
    end

    // Round half toward +inf, then saturate when the bits above the output sign disagree.
    always_comb begin
        shf  = SHF_W'(($signed({acc[ACC_W-1], acc}) + HALF) >>> COEF_FRAC);
        sat  = !((&shf[SHF_W-1:DATA_W-1]) || !(|shf[SHF_W-1:DATA_W-1]));
        conv = shf[DATA_W-1:0];
        if (sat) conv = shf[SHF_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout       <= '0;
            dout_valid <= '0;
            drop       <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            drop       <= reject;
            dout_valid <= '0;
            if (state == S_OUT) begin
                dout       <= conv;
                dout_valid <= N_CH'(1) << ch_q;
            end
            if (state == S_OUT && sat)
                ovf <= 1'b1;
            else if (ovf_clr)
                ovf <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fir_filter_mc.sv
// Scoreboard bench for fir_filter_mc: a direct-form FIR model predicts each result when the sample is accepted.
module tb_fir_filter_mc;
    localparam int TAPS = 8;
    localparam int LAT  = 14;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  din_valid = '0;
    logic [23:0] din = '0;
    logic        din_ready;
    logic [1:0]  dout_valid;
    logic [23:0] dout;
    logic        drop, ovf;
    logic        ovf_clr = 1'b0;
    logic        coef_we = 1'b0;
    logic [3:0]  coef_addr = '0;
    logic [34:0] coef_din = '0;

    fir_filter_mc #(.DATA_W(24), .COEF_W(35), .COEF_FRAC(31), .TAPS(TAPS), .N_CH(2), .MUL_LAT(4)) dut (
        .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .din_ready(din_ready),
        .dout_valid(dout_valid), .dout(dout), .drop(drop), .ovf(ovf), .ovf_clr(ovf_clr),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_din(coef_din)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    int acc_cyc = 0;

    typedef struct {
        logic [1:0]  ch;
        logic [23:0] dat;
    } exp_t;
    exp_t sb[$];

    logic signed [23:0] mx [2][TAPS];
    logic signed [34:0] mh [2][TAPS];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] model_out(input int c);
        logic signed [79:0] sum, xs, hs, r;
        sum = '0;
        for (int k = 0; k < TAPS; k++) begin
            xs  = mx[c][k];
            hs  = mh[c][k];
            sum = sum + xs * hs;
        end
        r = (sum + 80'sd1073741824) >>> 31;
        if (r > 80'sd8388607) return 24'h7FFFFF;
        if (r < -80'sd8388608) return 24'h800000;
        return r[23:0];
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 2; c++)
            for (int k = 0; k < TAPS; k++) mx[c][k] = '0;
    endtask

    task automatic write_coef(input int c, input int k, input logic [34:0] v);
        coef_we   = 1'b1;
        coef_addr = 4'(c * TAPS + k);
        coef_din  = v;
        tick();
        coef_we   = 1'b0;
        mh[c][k]  = v;
    endtask

    task automatic load_coefs(input int c, input logic [34:0] base, input logic [34:0] step, input bit tap0_only);
        for (int k = 0; k < TAPS; k++)
            write_coef(c, k, (tap0_only && k != 0) ? 35'd0 : base + step * 35'(k));
    endtask

    task automatic send(input logic [1:0] ch, input logic [23:0] x, input bit expect_out);
        int   n;
        int   c;
        exp_t e;
        n = 0;
        while (din_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (din_ready !== 1'b1) begin
            failures++;
            $display("FAIL send_ready got din_ready=%b want 1", din_ready);
        end
        c         = (ch == 2'b10) ? 1 : 0;
        din_valid = ch;
        din       = x;
        tick();
        din_valid = '0;
        acc_cyc   = cyc;
        for (int k = TAPS - 1; k > 0; k--) mx[c][k] = mx[c][k-1];
        mx[c][0] = x;
        if (expect_out) begin
            e.ch  = ch;
            e.dat = model_out(c);
            sb.push_back(e);
        end
    endtask

    // lat is the index of the cycle showing dout_valid, the cycle right after the acceptance edge being 1.
    task automatic wait_out(output logic [1:0] v, output logic [23:0] d, output int lat, output logic rdy);
        int n;
        n = 0;
        while (dout_valid === 2'b00 && n < 60) begin
            tick();
            n++;
        end
        v   = dout_valid;
        d   = dout;
        rdy = din_ready;
        lat = cyc - acc_cyc + 1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int n = 1; n <= 16; n++) begin
            checks++;
            if ({din_ready, dout_valid, dout, drop, ovf} !== '0) begin
                failures++;
                $display("FAIL reset_init cycle %0d got ready=%b vld=%b dout=%h drop=%b ovf=%b want all 0",
                         n, din_ready, dout_valid, dout, drop, ovf);
            end
            tick();
        end
        checks++;
        if (din_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got %b want 1", din_ready);
        end
    endtask

    task automatic test_impulse();
        logic [1:0] v; logic [23:0] d; int lat; logic rdy; exp_t e;
        do_reset();
        load_coefs(0, 35'd1 << 27, 35'd1 << 27, 1'b0);
        load_coefs(1, 35'd0, 35'd0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            send(2'b01, (i == 0) ? 24'h010000 : 24'h000000, 1'b1);
            wait_out(v, d, lat, rdy);
            e = sb.pop_front();
            checks += 4;
            if (v !== e.ch) begin failures++; $display("FAIL impulse_vld[%0d] got %b want %b", i, v, e.ch); end
            if (d !== e.dat) begin failures++; $display("FAIL impulse_dout[%0d] got %h want %h", i, d, e.dat); end
            if (lat !== LAT) begin failures++; $display("FAIL impulse_lat[%0d] got %0d want %0d", i, lat, LAT); end
            if (rdy !== 1'b1) begin failures++; $display("FAIL impulse_ready[%0d] got %b want 1", i, rdy); end
        end
    endtask

    task automatic test_isolation();
        logic [1:0] v; logic [23:0] d; int lat; logic rdy; exp_t e;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            for (int j = 0; j < 2; j++) begin
                send((j == 0) ? 2'b01 : 2'b10, (i == 0) ? 24'h010000 : 24'h000000, 1'b1);
                wait_out(v, d, lat, rdy);
                e = sb.pop_front();
                checks += 2;
                if (v !== e.ch) begin failures++; $display("FAIL iso_vld[%0d.%0d] got %b want %b", i, j, v, e.ch); end
                if (d !== e.dat) begin failures++; $display("FAIL iso_dout[%0d.%0d] got %h want %h", i, j, d, e.dat); end
            end
        end
    endtask

    task automatic test_rounding();
        logic [1:0] v; logic [23:0] d; int lat; logic rdy; exp_t e;
        logic [23:0] rx [3];
        rx = '{24'h000001, 24'hFFFFFF, 24'hFFFFFD};
        do_reset();
        load_coefs(0, 35'd1 << 30, 35'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            send(2'b01, rx[i], 1'b1);
            wait_out(v, d, lat, rdy);
            e = sb.pop_front();
            checks += 2;
            if (v !== e.ch) begin failures++; $display("FAIL round_vld[%0d] got %b want %b", i, v, e.ch); end
            if (d !== e.dat) begin failures++; $display("FAIL round_dout[%0d] x=%h got %h want %h", i, rx[i], d, e.dat); end
        end
    endtask

    task automatic test_saturation();
        logic [1:0] v; logic [23:0] d; int lat; logic rdy; exp_t e;
        logic [23:0] sx [2];
        sx = '{24'h7FFFFF, 24'h800000};
        load_coefs(0, 35'd1 << 31, 35'd0, 1'b0);
        for (int p = 0; p < 2; p++) begin
            do_reset();
            checks++;
            if (ovf !== 1'b0) begin failures++; $display("FAIL sat_ovf_start[%0d] got %b want 0", p, ovf); end
            for (int i = 0; i < TAPS; i++) begin
                send(2'b01, sx[p], 1'b1);
                wait_out(v, d, lat, rdy);
                e = sb.pop_front();
                checks++;
                if (d !== e.dat) begin failures++; $display("FAIL sat_dout[%0d.%0d] got %h want %h", p, i, d, e.dat); end
            end
            checks++;
            if (ovf !== 1'b1) begin failures++; $display("FAIL sat_ovf_set[%0d] got %b want 1", p, ovf); end
            ovf_clr = 1'b1;
            tick();
            ovf_clr = 1'b0;
            checks++;
            if (ovf !== 1'b0) begin failures++; $display("FAIL sat_ovf_clr[%0d] got %b want 0", p, ovf); end
        end
    endtask

    task automatic test_drop_abort();
        logic [1:0] v; logic [23:0] d; int lat; logic rdy; exp_t e;
        bit seen;
        do_reset();
        load_coefs(0, 35'd1 << 27, 35'd1 << 27, 1'b0);
        send(2'b01, 24'h010000, 1'b1);
        din_valid = 2'b01;
        din       = 24'h123456;
        tick();
        din_valid = '0;
        checks++;
        if (drop !== 1'b1) begin failures++; $display("FAIL drop_run_pulse got %b want 1", drop); end
        tick();
        checks++;
        if (drop !== 1'b0) begin failures++; $display("FAIL drop_run_clear got %b want 0", drop); end
        wait_out(v, d, lat, rdy);
        e = sb.pop_front();
        checks += 2;
        if (d !== e.dat) begin failures++; $display("FAIL drop_run_dout got %h want %h", d, e.dat); end
        if (lat !== LAT) begin failures++; $display("FAIL drop_run_lat got %0d want %0d", lat, LAT); end

        din_valid = 2'b11;
        din       = 24'h0ABCDE;
        tick();
        din_valid = '0;
        checks += 2;
        if (drop !== 1'b1) begin failures++; $display("FAIL drop_multi_pulse got %b want 1", drop); end
        if (din_ready !== 1'b1) begin failures++; $display("FAIL drop_multi_ready got %b want 1", din_ready); end
        send(2'b01, 24'h000000, 1'b1);
        wait_out(v, d, lat, rdy);
        e = sb.pop_front();
        checks++;
        if (d !== e.dat) begin failures++; $display("FAIL drop_multi_dout got %h want %h", d, e.dat); end

        send(2'b01, 24'h010000, 1'b0);
        repeat (3) tick();
        do_reset();
        seen = 1'b0;
        for (int n = 0; n < 30; n++) begin
            if (dout_valid !== 2'b00) seen = 1'b1;
            tick();
        end
        checks++;
        if (seen) begin failures++; $display("FAIL abort_no_valid got a dout_valid want none"); end
        for (int i = 0; i < 3; i++) begin
            send(2'b01, (i == 0) ? 24'h010000 : 24'h000000, 1'b1);
            wait_out(v, d, lat, rdy);
            e = sb.pop_front();
            checks += 2;
            if (v !== e.ch) begin failures++; $display("FAIL abort_vld[%0d] got %b want %b", i, v, e.ch); end
            if (d !== e.dat) begin failures++; $display("FAIL abort_dout[%0d] got %h want %h", i, d, e.dat); end
        end
    endtask

    initial begin
        for (int c = 0; c < 2; c++)
            for (int k = 0; k < TAPS; k++) begin
                mx[c][k] = '0;
                mh[c][k] = '0;
            end
        test_reset();
        test_impulse();
        test_isolation();
        test_rounding();
        test_saturation();
        test_drop_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired before the bench completed");
        $fatal(1);
    end
endmodule
